mux_pipe_n: RTL and testbench

MUX_PIPE_N -- requirements
Module: mux_pipe_n

---
 rtl/mux_pkg.sv | 13 +
 rtl/mux_n_sel.sv | 28 ++
 rtl/mux_pipe_n.sv | 89 ++++++++
 tb/tb_mux_pipe_n.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared defaults and select clamping for the pipelined N-input multiplexer.
// The clamp encodes the legacy rule: an out-of-range select picks the last input.
package mux_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_N_IN  = 9;
    localparam int DEF_SEL_W = 4;

    function automatic int clamp_sel(input int sel_val, input int n_in);
        return (sel_val >= n_in) ? n_in - 1 : sel_val;
    endfunction

endpackage

// File: rtl/mux_n_sel.sv
// Combinational N-way word select from a flattened input bus.
// Out-of-range selects fall back to the last input.
module mux_n_sel
    import mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_IN  = DEF_N_IN,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic [N_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out
);

    int idx;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
        out = '0;
        idx = clamp_sel(int'(sel), N_IN);
        for (int k = 0; k < N_IN; k++) begin
            if (k == idx) begin
                out = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_pipe_n.sv
// Registered N-input multiplexer with a 2-entry skid buffer on a valid/ready stream.
// in_ready depends only on the skid register, never on out_ready.
module mux_pipe_n
    import mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_IN  = DEF_N_IN,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  err_clr,
    output logic                  sel_err
);

    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             main_valid;
    logic             skid_valid;
    logic             in_xfer;
    logic             out_xfer;
    logic             sel_bad;

    mux_n_sel #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) u_sel (
        .in_bus (in_bus),
        .sel    (sel),
        .out    (sel_data)
    );

    assign in_ready  = ~skid_valid;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = main_valid & out_ready;
    assign sel_bad   = (int'(sel) >= N_IN);
    assign out       = main_data;
    assign out_valid = main_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: data registers are reset too, so out reads 0 rather than stale data after reset.
            main_data  <= '0;
            skid_data  <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_xfer) begin
            // Main drains: refill from skid first to keep order, else from the input.
            if (skid_valid) begin
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (in_xfer) begin
                main_data  <= sel_data;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            if (!main_valid) begin
                // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
                main_data  <= sel_data;
                main_valid <= 1'b1;
            end else begin
                skid_data  <= sel_data;
                skid_valid <= 1'b1;
            end
        end
    end

    // Set has priority over clear so a bad select is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_err <= 1'b0;
        end else if (in_xfer && sel_bad) begin
            sel_err <= 1'b1;
        end else if (err_clr) begin
            sel_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_pipe_n.sv
// Scoreboard bench for mux_pipe_n: directed tests on a default instance,
// randomized stream on a WIDTH=8, N_IN=5 instance.
module tb_mux_pipe_n;

    localparam int AW = 32;
    localparam int AN = 9;
    localparam int AS = 4;
    localparam int BW = 8;
    localparam int BN = 5;
    localparam int BS = 3;
    localparam int N_WORDS = 1000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [AN*AW-1:0] a_in_bus;
    logic [AS-1:0]    a_sel;
    logic             a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_err_clr, a_sel_err;
    logic [AW-1:0]    a_out;

    logic [BN*BW-1:0] b_in_bus;
    logic [BS-1:0]    b_sel;
    logic             b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err_clr, b_sel_err;
    logic [BW-1:0]    b_out;

    mux_pipe_n #(.WIDTH(AW), .N_IN(AN), .SEL_W(AS)) dut_a (
        .clk(clk), .reset(reset), .in_bus(a_in_bus), .sel(a_sel),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .out(a_out),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .err_clr(a_err_clr), .sel_err(a_sel_err)
    );

    mux_pipe_n #(.WIDTH(BW), .N_IN(BN), .SEL_W(BS)) dut_b (
        .clk(clk), .reset(reset), .in_bus(b_in_bus), .sel(b_sel),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out(b_out),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .err_clr(b_err_clr), .sel_err(b_sel_err)
    );

    int checks = 0;
    int errors = 0;
    int b_rcv  = 0;
    logic [AW-1:0] qa[$];
    logic [BW-1:0] qb[$];
    logic erra = 1'b0;
    logic errb = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pick input sel, or the last input when sel is out of range.
    function automatic logic [AW-1:0] ref_a(input logic [AN*AW-1:0] bus, input logic [AS-1:0] s);
        int idx;
        idx = (int'(s) < AN) ? int'(s) : AN - 1;
        return bus[idx*AW +: AW];
    endfunction

    function automatic logic [BW-1:0] ref_b(input logic [BN*BW-1:0] bus, input logic [BS-1:0] s);
        int idx;
        idx = (int'(s) < BN) ? int'(s) : BN - 1;
        return bus[idx*BW +: BW];
    endfunction

    // Monitors sample mid-cycle; inputs change 1 time unit after the rising edge.
    always @(negedge clk) begin
        if (reset) begin
            qa.delete();
            erra = 1'b0;
        end else begin
            check("a_sel_err", a_sel_err, erra);
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) check("a_out_spurious", a_out_valid, 1'b0);
                else check("a_out", a_out, qa.pop_front());
            end
            if (a_in_valid && a_in_ready) begin
                qa.push_back(ref_a(a_in_bus, a_sel));
                if (int'(a_sel) >= AN) erra = 1'b1;
                else if (a_err_clr) erra = 1'b0;
            end else if (a_err_clr) begin
                erra = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            qb.delete();
            errb = 1'b0;
        end else begin
            check("b_sel_err", b_sel_err, errb);
            if (b_out_valid && b_out_ready) begin
                b_rcv++;
                if (qb.size() == 0) check("b_out_spurious", b_out_valid, 1'b0);
                else check("b_out", b_out, qb.pop_front());
            end
            if (b_in_valid && b_in_ready) begin
                qb.push_back(ref_b(b_in_bus, b_sel));
                if (int'(b_sel) >= BN) errb = 1'b1;
                else if (b_err_clr) errb = 1'b0;
            end else if (b_err_clr) begin
                errb = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int cyc;
        reset = 1'b1;
        a_in_bus = '0; a_sel = '0; a_in_valid = 1'b0; a_out_ready = 1'b1; a_err_clr = 1'b0;
        b_in_bus = '0; b_sel = '0; b_in_valid = 1'b0; b_out_ready = 1'b1; b_err_clr = 1'b0;
        #2;
        check("rst_out_valid", a_out_valid, 1'b0);
        check("rst_sel_err", a_sel_err, 1'b0);
        check("rst_out", a_out, 32'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        tick();
        check("post_rst_in_ready", a_in_ready, 1'b1);

        // Full-throughput walk through every input.
        for (int k = 0; k < AN; k++) a_in_bus[k*AW +: AW] = 32'hA0 + k;
        for (int s = 0; s < AN; s++) begin
            check("stream_in_ready", a_in_ready, 1'b1);
            a_sel = AS'(s);
            a_in_valid = 1'b1;
            tick();
            check("stream_out", a_out, 32'hA0 + s);
            check("stream_out_valid", a_out_valid, 1'b1);
        end
        a_in_valid = 1'b0;
        tick();
        check("drain_out_valid", a_out_valid, 1'b0);

        // Out-of-range select: default-to-last and sticky error.
        a_in_bus[8*AW +: AW] = 32'hDEAD_BEEF;
        a_sel = 4'd12;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        check("bad_sel_out", a_out, 32'hDEAD_BEEF);
        check("bad_sel_err_set", a_sel_err, 1'b1);
        tick();
        check("bad_sel_err_sticky", a_sel_err, 1'b1);
        a_err_clr = 1'b1;
        tick();
        a_err_clr = 1'b0;
        check("err_clr", a_sel_err, 1'b0);
        a_in_valid = 1'b1;
        a_err_clr = 1'b1;
        tick();
        a_in_valid = 1'b0;
        a_err_clr = 1'b0;
        check("set_wins_clr", a_sel_err, 1'b1);
        a_err_clr = 1'b1;
        tick();
        a_err_clr = 1'b0;
        check("err_clr2", a_sel_err, 1'b0);
        tick();

        // Backpressure fills the skid register.
        a_out_ready = 1'b0;
        a_sel = 4'd0;
        a_in_bus[0 +: AW] = 32'd1;
        a_in_valid = 1'b1;
        tick();
        check("bp_in_ready_one", a_in_ready, 1'b1);
        a_in_bus[0 +: AW] = 32'd2;
        tick();
        a_in_valid = 1'b0;
        check("bp_in_ready_full", a_in_ready, 1'b0);
        check("bp_out_hold", a_out, 32'd1);
        tick();
        check("bp_out_stable", a_out, 32'd1);
        check("bp_out_valid", a_out_valid, 1'b1);
        a_out_ready = 1'b1;
        tick();
        check("bp_out_second", a_out, 32'd2);
        check("bp_in_ready_back", a_in_ready, 1'b1);
        tick();
        check("bp_out_empty", a_out_valid, 1'b0);

        // Asynchronous reset with skid full and error set.
        a_out_ready = 1'b0;
        a_sel = 4'd13;
        a_in_valid = 1'b1;
        tick();
        tick();
        a_in_valid = 1'b0;
        check("pre_rst_in_ready", a_in_ready, 1'b0);
        check("pre_rst_sel_err", a_sel_err, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async_out_valid", a_out_valid, 1'b0);
        check("async_sel_err", a_sel_err, 1'b0);
        check("async_in_ready", a_in_ready, 1'b1);
        check("async_out", a_out, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        a_out_ready = 1'b1;
        tick();
        check("rel_in_ready", a_in_ready, 1'b1);
        check("rel_out_valid", a_out_valid, 1'b0);

        // Random stream on the narrow instance.
        sent = 0;
        cyc = 0;
        while (sent < N_WORDS && cyc < 20000) begin
            b_out_ready = 1'($urandom_range(0, 1));
            b_in_valid  = 1'($urandom_range(0, 1));
            b_sel       = BS'($urandom_range(0, 7));
            b_err_clr   = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < BN; k++) b_in_bus[k*BW +: BW] = 8'($urandom);
            if (b_in_valid && b_in_ready) sent++;
            tick();
            cyc++;
        end
        check("b_send_count", 64'(sent), 64'(N_WORDS));
        b_in_valid = 1'b0;
        b_err_clr = 1'b0;
        b_out_ready = 1'b1;
        cyc = 0;
        while ((b_out_valid || qb.size() != 0) && cyc < 10) begin
            tick();
            cyc++;
        end
        check("b_drain_valid", b_out_valid, 1'b0);
        check("b_drain_queue", 64'(qb.size()), 64'd0);
        check("b_rcv_count", 64'(b_rcv), 64'(N_WORDS));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
